// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core (MEM stage) vs DMA/debug loader, core priority with starvation-forced DMA slot.
// Optional DMEM_ARB_PERF_EN adds stall_cycles / dma_grants performance counters.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    input  logic                  core_halt,
    output logic                  core_stall,
    output logic [DATA_W-1:0]     core_rdata,
    input  logic                  dma_valid,
    input  logic                  dma_we,
    input  logic [DM_ADDRESS-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wdata,
    output logic                  dma_ready,
    output logic                  dma_rsp_valid,
    output logic [DATA_W-1:0]     dma_rsp_data,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_func3,
    input  logic [DATA_W-1:0]     mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           dma_grants
`endif
);

    typedef enum logic [1:0] {G_NONE, G_CORE, G_DMA} grant_t;

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    grant_t            grant_q, grant_d;
    logic [CNT_W-1:0]  starve_cnt;
    logic              core_req;
    logic              forced;
    logic              rsp_vld_q;
    logic [DATA_W-1:0] rsp_dat_q;

    always_ff @(posedge clk) begin
        if (reset) grant_q <= G_NONE;
        else       grant_q <= grant_d;
    end

    // Owner of this cycle is decided combinationally; grant_q only remembers it.
    always_comb begin
        core_req   = core_rd | core_wr;
        // A DMA slot last cycle has already cleared the counter, so the core regains priority.
        forced     = dma_valid && (starve_cnt == LIM) && (grant_q != G_DMA);
        grant_d    = G_NONE;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_func3  = 3'b000;
        core_rdata = '0;
        core_stall = 1'b0;
        dma_ready  = 1'b0;
        if (reset)                      grant_d = G_NONE;
        else if (core_halt && dma_valid) grant_d = G_DMA;
        else if (forced)                grant_d = G_DMA;
        else if (core_req)              grant_d = G_CORE;
        else if (dma_valid)             grant_d = G_DMA;
        case (grant_d)
            G_CORE: begin
                mem_rd     = core_rd;
                mem_wr     = core_wr;
                mem_addr   = core_addr;
                mem_wdata  = core_wdata;
                mem_func3  = core_func3;
                core_rdata = mem_rdata;
            end
            G_DMA: begin
                mem_rd     = ~dma_we;
                mem_wr     = dma_we;
                mem_addr   = dma_addr;
                mem_wdata  = dma_wdata;
                mem_func3  = 3'b010;
                dma_ready  = 1'b1;
                core_stall = core_req & ~core_halt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_d == G_DMA || !dma_valid) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIM) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
        end else begin
            rsp_vld_q <= (grant_d == G_DMA) && !dma_we;
            if (grant_d == G_DMA && !dma_we) rsp_dat_q <= mem_rdata;
        end
    end

    // Gated so a response pending across reset is dropped.
    always_comb begin
        dma_rsp_valid = rsp_vld_q & ~reset;
        dma_rsp_data  = reset ? '0 : rsp_dat_q;
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            dma_grants   <= '0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, core_stall};
            dma_grants   <= dma_grants + {31'd0, dma_ready};
        end
    end
`endif

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipeline MEM stage (core port) and a DMA/debug loader port using valid/ready handshakes. The core has priority. A starvation counter forces a DMA slot after STARVE_LIM waiting cycles, and core_stall freezes the pipeline during that slot. The block sits between the EX/MEM register outputs and datamemory.

Parameters:
DM_ADDRESS, 9, data memory byte-address width
DATA_W, 32, data width
STARVE_LIM, 4, consecutive DMA-waiting cycles before a forced DMA grant (1..15)
CNT_W, 4, starvation counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
core_rd  in  1  MEM-stage read request
core_wr  in  1  MEM-stage write request
core_addr  in  DM_ADDRESS  core byte address
core_wdata  in  DATA_W  core store data
core_func3  in  3  core access size/sign
core_halt  in  1  core halted; DMA gets absolute priority
core_stall  out  1  core access not performed this cycle; hold pipeline
core_rdata  out  DATA_W  core load data
dma_valid  in  1  DMA request valid
dma_we  in  1  1 = write, 0 = read
dma_addr  in  DM_ADDRESS  DMA byte address
dma_wdata  in  DATA_W  DMA write data
dma_ready  out  1  DMA request accepted this cycle
dma_rsp_valid  out  1  DMA read data valid
dma_rsp_data  out  DATA_W  DMA read data
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable
mem_addr  out  DM_ADDRESS  memory address
mem_wdata  out  DATA_W  memory write data
mem_func3  out  3  memory access size
mem_rdata  in  DATA_W  memory read data, combinational w.r.t. mem_addr/mem_rd

Behaviour:
- Clock is clk; reset is synchronous and active-high, sampled on posedge clk.
- Grant decision is combinational each cycle. core_req = core_rd | core_wr.
- Priority order:
  - core_halt=1: DMA wins whenever dma_valid.
  - else if dma_valid and starve_cnt==STARVE_LIM: DMA wins (forced slot).
  - else if core_req: core wins.
  - else if dma_valid: DMA wins.
  - else idle; mem_rd and mem_wr are 0.
- Core grant: mem_* driven from core_*; core_rdata = mem_rdata in the same cycle; core_stall=0.
- DMA grant:
  - mem_rd = ~dma_we, mem_wr = dma_we, mem_addr = dma_addr, mem_wdata = dma_wdata, mem_func3 = 3'b010 (word only).
  - dma_ready=1.
  - core_stall = core_req & ~core_halt.
- DMA read response is registered: dma_rsp_valid=1 exactly one cycle after an accepted read, and dma_rsp_data holds the mem_rdata captured at grant. There is no response backpressure.
- DMA writes produce no response.
- Starvation counter starve_cnt[CNT_W]:
  - Cleared on a DMA grant or when dma_valid=0.
  - Otherwise increments each cycle dma_valid=1 and the DMA is not granted; saturates at STARVE_LIM.
- Grant-owner FSM grant_q ∈ {G_NONE, G_CORE, G_DMA}: records last cycle's owner. G_DMA after a forced grant immediately returns priority to the core next cycle (no back-to-back forced slots).
- Core inputs are held stable by the pipeline while core_stall=1. The arbiter does not latch them.
- Boundaries:
  - dma_valid deasserted while waiting: counter clears.
  - STARVE_LIM reached with core idle: normal DMA grant, counter clears.
  - core_halt toggles mid-wait: counter behaviour unchanged.
- Reset values:
  - core_stall=0, dma_ready=0, dma_rsp_valid=0, dma_rsp_data=0, mem_rd=0, mem_wr=0.
  - mem_addr, mem_wdata, mem_func3 = 0.
  - starve_cnt=0, grant_q=G_NONE.
  - A DMA read pending at reset is dropped (no rsp_valid).
  - All combinational outputs are forced to 0 while reset=1.

Optional Feature:
DMEM_ARB_PERF_EN. When defined, adds two outputs, stall_cycles[31:0] and dma_grants[31:0].
- stall_cycles counts cycles with core_stall=1.
- dma_grants counts cycles with dma_ready=1.
- Both are cleared by reset and wrap modulo 2^32.
When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
1. Core only: core_rd=1, addr=0x010, memory holds 0xDEADBEEF -> mem_rd=1, core_rdata=0xDEADBEEF same cycle, core_stall=0, dma_ready=0.
2. DMA only: dma_valid=1, dma_we=1, addr=0x020, wdata=0x12345678 -> dma_ready=1, mem_wr=1, mem_func3=010; a DMA read of 0x020 next gives dma_rsp_valid=1 one cycle later with data 0x12345678.
3. Starvation (STARVE_LIM=4): core_req and dma_valid both held high -> core granted cycles 0-3, DMA granted cycle 4 with core_stall=1, core granted cycle 5, DMA forced again at cycle 9.
4. core_halt=1 with core_rd=1 and dma_valid=1 -> DMA granted every cycle, core_stall=0, starve_cnt stays 0.
5. Reset mid-read: DMA read accepted, reset asserted the next cycle -> dma_rsp_valid stays 0, all outputs 0, starve_cnt=0.
6. With DMEM_ARB_PERF_EN defined, run scenario 3 for 10 cycles -> stall_cycles=2, dma_grants=2.
